// File: rtl/dm_cache.sv
// Direct-mapped write-through cache, one word per line.
// Read-allocate, no-write-allocate; transparent to the CPU.
`ifndef ADDRWIDTH
`define ADDRWIDTH 16
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 32
`endif
`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'd0
`endif
`ifndef RD
`define RD 2'd1
`endif
`ifndef WT
`define WT 2'd2
`endif

module dm_cache #(
  parameter int INDEX_WIDTH = 3,
  parameter int TAG_WIDTH   = `ADDRWIDTH - INDEX_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [`IOSTATEWIDTH-1:0] rwToMem,
  input  logic [`ADDRWIDTH-1:0]    addrToMem,
  input  logic [`WORDWIDTH-1:0]    dataToMem,
  output logic                     cacheEn,
  output logic [`WORDWIDTH-1:0]    dataFromMem,
  input  logic                     flush,
  output logic [`IOSTATEWIDTH-1:0] memRw,
  output logic [`ADDRWIDTH-1:0]    memAddr,
  output logic [`WORDWIDTH-1:0]    memDataOut,
  input  logic [`WORDWIDTH-1:0]    memDataIn,
  input  logic                     memReady,
  output logic [CNT_WIDTH-1:0]     hitCount,
  output logic [CNT_WIDTH-1:0]     missCount
);

  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MEMRD,
    MEMWT,
    DONE
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_WIDTH-1:0]    tags  [LINES];
  logic [`WORDWIDTH-1:0]   lines [LINES];

  logic [INDEX_WIDTH-1:0]  idx;
  logic [TAG_WIDTH-1:0]    tag;
  logic                    hit;
  logic                    is_rd;
  logic                    is_wt;
  logic                    fill;
  logic                    wr_hit;
  logic                    line_we;
  logic [`WORDWIDTH-1:0]   line_wd;

  assign idx   = addrToMem[INDEX_WIDTH-1:0];
  assign tag   = addrToMem[`ADDRWIDTH-1 -: TAG_WIDTH];
  assign hit   = valid[idx] && (tags[idx] == tag);
  assign is_rd = (rwToMem == `RD);
  assign is_wt = (rwToMem == `WT);

  always_comb begin
    fill    = (state == MEMRD) && memReady;
    wr_hit  = (state == IDLE) && !flush && is_wt && hit;
    line_we = !reset && (fill || wr_hit);
    line_wd = fill ? memDataIn : dataToMem;
  end

  // Tag/data storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx]  <= tag;
      lines[idx] <= line_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      cacheEn     <= 1'b0;
      dataFromMem <= '0;
      memRw       <= `IDEL;
      memAddr     <= '0;
      memDataOut  <= '0;
      hitCount    <= '0;
      missCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (is_rd) begin
            if (hit) begin
              dataFromMem <= lines[idx];
              cacheEn     <= 1'b1;
              hitCount    <= hitCount + CNT_WIDTH'(1);
              state       <= DONE;
            end else begin
              memRw     <= `RD;
              memAddr   <= addrToMem;
              missCount <= missCount + CNT_WIDTH'(1);
              state     <= MEMRD;
            end
          end else if (is_wt) begin
            if (hit) hitCount <= hitCount + CNT_WIDTH'(1);
            else     missCount <= missCount + CNT_WIDTH'(1);
            memRw      <= `WT;
            memAddr    <= addrToMem;
            memDataOut <= dataToMem;
            state      <= MEMWT;
          end
        end
        MEMRD: begin
          if (memReady) begin
            valid[idx]  <= 1'b1;
            dataFromMem <= memDataIn;
            cacheEn     <= 1'b1;
            memRw       <= `IDEL;
            state       <= DONE;
          end
        end
        MEMWT: begin
          if (memReady) begin
            cacheEn <= 1'b1;
            memRw   <= `IDEL;
            state   <= DONE;
          end
        end
        DONE: begin
          cacheEn <= 1'b0;
          // Wait out the CPU's stale request from its ack cycle.
          if (rwToMem == `IDEL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache with a small latency-3 memory model.
// Expected values are hand-computed from the test plan.
`ifndef ADDRWIDTH
`define ADDRWIDTH 16
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 32
`endif
`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'd0
`endif
`ifndef RD
`define RD 2'd1
`endif
`ifndef WT
`define WT 2'd2
`endif

module tb_dm_cache;

  localparam int LAT = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [`IOSTATEWIDTH-1:0] rwToMem;
  logic [`ADDRWIDTH-1:0]    addrToMem;
  logic [`WORDWIDTH-1:0]    dataToMem;
  logic                     cacheEn;
  logic [`WORDWIDTH-1:0]    dataFromMem;
  logic                     flush;
  logic [`IOSTATEWIDTH-1:0] memRw;
  logic [`ADDRWIDTH-1:0]    memAddr;
  logic [`WORDWIDTH-1:0]    memDataOut;
  logic [`WORDWIDTH-1:0]    memDataIn;
  logic                     memReady;
  logic [15:0]              hitCount;
  logic [15:0]              missCount;

  dm_cache dut (
    .clk        (clk),
    .reset      (reset),
    .rwToMem    (rwToMem),
    .addrToMem  (addrToMem),
    .dataToMem  (dataToMem),
    .cacheEn    (cacheEn),
    .dataFromMem(dataFromMem),
    .flush      (flush),
    .memRw      (memRw),
    .memAddr    (memAddr),
    .memDataOut (memDataOut),
    .memDataIn  (memDataIn),
    .memReady   (memReady),
    .hitCount   (hitCount),
    .missCount  (missCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [16];
  logic [1:0]  last_rw;
  logic [15:0] last_addr;
  logic [31:0] last_wd;
  logic [31:0] rdata;
  int          reqs;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One CPU transaction, with memory answering LAT cycles after a request.
  task automatic access(input logic [1:0] rw, input logic [15:0] a,
                        input logic [31:0] d);
    int  wn;
    bit  pend;
    bit  done;
    rwToMem   = rw;
    addrToMem = a;
    dataToMem = d;
    reqs = 0;
    cyc  = 0;
    pend = 0;
    done = 0;
    wn   = 0;
    rdata = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      memReady = 1'b0;
      if (cacheEn) begin
        rdata = dataFromMem;
        done  = 1;
      end else begin
        if (memRw != `IDEL && !pend) begin
          pend = 1;
          reqs++;
          last_rw   = memRw;
          last_addr = memAddr;
          last_wd   = memDataOut;
          wn = 0;
        end
        if (pend) begin
          wn++;
          if (wn == LAT) begin
            memReady  = 1'b1;
            memDataIn = (memRw == `RD) ? mem[memAddr[3:0]] : 32'h0;
            if (memRw == `WT) mem[memAddr[3:0]] = memDataOut;
            pend = 0;
          end
        end
      end
    end
    if (!done) chk("timeout", 32'(cacheEn), 32'd1);
    // CPU still drives the request during its ack cycle.
    @(posedge clk);
    #1;
    chk("pulse1", 32'(cacheEn), 32'd0);
    chk("noreacc", 32'(memRw), 32'(`IDEL));
    rwToMem = `IDEL;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[5]  = 32'hAB;
    mem[13] = 32'h11;
    reset = 1'b1;
    rwToMem = `IDEL;
    addrToMem = '0;
    dataToMem = '0;
    flush = 1'b0;
    memDataIn = '0;
    memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(cacheEn), 32'd0);
    chk("rst_rw", 32'(memRw), 32'(`IDEL));
    chk("rst_addr", 32'(memAddr), 32'd0);
    chk("rst_dout", memDataOut, 32'd0);
    chk("rst_rdata", dataFromMem, 32'd0);
    chk("rst_hit", 32'(hitCount), 32'd0);
    chk("rst_miss", 32'(missCount), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: cold miss
    access(`RD, 16'h05, 32'h0);
    chk("t1_reqs", reqs, 1);
    chk("t1_rw", 32'(last_rw), 32'(`RD));
    chk("t1_addr", 32'(last_addr), 32'h05);
    chk("t1_data", rdata, 32'hAB);
    chk("t1_miss", 32'(missCount), 32'd1);

    // 2: hit, one cycle latency
    access(`RD, 16'h05, 32'h0);
    chk("t2_reqs", reqs, 0);
    chk("t2_cyc", cyc, 1);
    chk("t2_data", rdata, 32'hAB);
    chk("t2_hit", 32'(hitCount), 32'd1);

    // 3: conflict on index 5
    access(`RD, 16'h0D, 32'h0);
    chk("t3a_reqs", reqs, 1);
    chk("t3a_data", rdata, 32'h11);
    access(`RD, 16'h05, 32'h0);
    chk("t3b_reqs", reqs, 1);
    chk("t3b_data", rdata, 32'hAB);
    chk("t3_miss", 32'(missCount), 32'd3);
    access(`RD, 16'h05, 32'h0);
    chk("t3c_reqs", reqs, 0);
    chk("t3c_data", rdata, 32'hAB);
    chk("t3_hit", 32'(hitCount), 32'd2);

    // 4: write hit updates line, write miss does not allocate
    access(`WT, 16'h05, 32'h77);
    chk("t4a_reqs", reqs, 1);
    chk("t4a_rw", 32'(last_rw), 32'(`WT));
    chk("t4a_addr", 32'(last_addr), 32'h05);
    chk("t4a_wd", last_wd, 32'h77);
    chk("t4a_hit", 32'(hitCount), 32'd3);
    access(`RD, 16'h05, 32'h0);
    chk("t4b_reqs", reqs, 0);
    chk("t4b_data", rdata, 32'h77);
    chk("t4b_hit", 32'(hitCount), 32'd4);
    access(`WT, 16'h06, 32'h99);
    chk("t4c_reqs", reqs, 1);
    chk("t4c_miss", 32'(missCount), 32'd4);
    access(`RD, 16'h06, 32'h0);
    chk("t4d_reqs", reqs, 1);
    chk("t4d_data", rdata, 32'h99);
    chk("t4d_miss", 32'(missCount), 32'd5);

    // 5: flush blocks acceptance that edge, then line is invalid
    flush = 1'b1;
    rwToMem = `RD;
    addrToMem = 16'h05;
    @(posedge clk);
    #1;
    chk("t5_en", 32'(cacheEn), 32'd0);
    chk("t5_rw", 32'(memRw), 32'(`IDEL));
    flush = 1'b0;
    access(`RD, 16'h05, 32'h0);
    chk("t5_reqs", reqs, 1);
    chk("t5_data", rdata, 32'h77);
    chk("t5_miss", 32'(missCount), 32'd6);
    chk("t5_hit", 32'(hitCount), 32'd4);

    // 6: reset while waiting on memory
    rwToMem = `RD;
    addrToMem = 16'h0D;
    @(posedge clk);
    #1;
    chk("t6_rw", 32'(memRw), 32'(`RD));
    @(posedge clk);
    #1;
    reset = 1'b1;
    rwToMem = `IDEL;
    @(posedge clk);
    #1;
    chk("t6_rwidle", 32'(memRw), 32'(`IDEL));
    chk("t6_en", 32'(cacheEn), 32'd0);
    chk("t6_hit", 32'(hitCount), 32'd0);
    chk("t6_miss", 32'(missCount), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_en2", 32'(cacheEn), 32'd0);
    access(`RD, 16'h05, 32'h0);
    chk("t6_reqs", reqs, 1);
    chk("t6_data", rdata, 32'h77);
    chk("t6_miss2", 32'(missCount), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Direct-mapped, write-through, read-allocate / no-write-allocate cache.
- Sits between the CPU memory port and main memory. It is the responder for the CPU's rwToMem/addrToMem/dataToMem request and answers with cacheEn/dataFromMem.
- Acts as initiator toward main memory using the same request/ready protocol.
- The cache is transparent to the CPU; only latency varies.

Parameters:
- INDEX_WIDTH, 3, line-index bits; lines = 2**INDEX_WIDTH, one word per line.
- TAG_WIDTH, `ADDRWIDTH-INDEX_WIDTH, tag bits stored per line (derived).
- CNT_WIDTH, 16, width of hit/miss counters.

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- rwToMem  input  `IOSTATEWIDTH  CPU request: `IDEL / `RD / `WT
- addrToMem  input  `ADDRWIDTH  CPU word address
- dataToMem  input  `WORDWIDTH  CPU write data
- cacheEn  output  1  one-cycle completion pulse to CPU
- dataFromMem  output  `WORDWIDTH  read data to CPU, valid while cacheEn=1
- flush  input  1  invalidate all lines
- memRw  output  `IOSTATEWIDTH  request to main memory
- memAddr  output  `ADDRWIDTH  main-memory address
- memDataOut  output  `WORDWIDTH  main-memory write data
- memDataIn  input  `WORDWIDTH  main-memory read data, valid with memReady
- memReady  input  1  main-memory completion
- hitCount  output  CNT_WIDTH  debug: read+write hits, wraps
- missCount  output  CNT_WIDTH  debug: read+write misses, wraps

Behaviour:
- Address split: index = addrToMem[INDEX_WIDTH-1:0]; tag = upper TAG_WIDTH bits. Hit = valid[index] && tag match.
- All outputs are registered.
- Reset: state=IDLE, all valid bits=0, cacheEn=0, dataFromMem=0, memRw=`IDEL, memAddr=0, memDataOut=0, hitCount=0, missCount=0. Reset mid-miss abandons the memory transaction (memRw=`IDEL next cycle) and produces no cacheEn.
- States: IDLE, MEMRD, MEMWT, DONE.
- IDLE:
  - flush=1: clear all valid bits; no request accepted this edge; the CPU keeps holding its request, so it is accepted on a later edge.
  - rwToMem=`RD, hit: dataFromMem=line data, cacheEn=1, hitCount+1, go DONE. cacheEn is visible 1 cycle after the request is sampled.
  - rwToMem=`RD, miss: memRw=`RD, memAddr=addrToMem, missCount+1, go MEMRD.
  - rwToMem=`WT: if hit, line data=dataToMem and hitCount+1; else missCount+1 and the line is untouched. In both cases memRw=`WT, memAddr=addrToMem, memDataOut=dataToMem, go MEMWT.
  - Any other rwToMem value, including `IDEL: stay IDLE, no action.
- MEMRD: wait for memReady=1. On that edge:
  - write line: valid=1, tag, data=memDataIn;
  - dataFromMem=memDataIn, cacheEn=1, memRw=`IDEL;
  - go DONE.
  - memAddr/memRw are held stable until then.
- MEMWT: wait for memReady=1. On that edge: cacheEn=1, memRw=`IDEL, go DONE. dataFromMem is unchanged.
- DONE:
  - cacheEn is forced to 0 on the first edge in DONE (exactly one-cycle pulse).
  - Return to IDLE on an edge where rwToMem=`IDEL. This prevents re-accepting the stale request the CPU is still driving during its acknowledge cycle.
- flush is ignored outside IDLE.
- The CPU holds addr/data stable from request until it samples cacheEn. The cache latches nothing else.
- Counters wrap at 2**CNT_WIDTH.
- Memory latency is unbounded; no timeout.

Test Plan:
1. Reset, then `RD 0x05 with memory returning 0xAB after 3 cycles.
   -> memRw=`RD, memAddr=0x05; cacheEn pulses once with dataFromMem=0xAB; missCount=1.
2. Repeat `RD 0x05.
   -> no memRw activity; cacheEn 1 cycle after request with 0xAB; hitCount=1.
3. Conflict: `RD 0x0D (same index 5, memory returns 0x11), then `RD 0x05.
   -> both miss (missCount=3); line 5 holds tag of 0x05 and data 0xAB afterwards.
4. `WT 0x05 data 0x77 (hit), then `RD 0x05.
   -> memRw=`WT, memDataOut=0x77; the read then hits and returns 0x77.
   `WT 0x06 (miss), then `RD 0x06.
   -> the read misses (no allocate).
5. flush asserted together with `RD 0x05 in IDLE.
   -> request not taken that edge; the following `RD 0x05 misses.
   cacheEn is never high for more than 1 cycle; no double acceptance.
6. Assert reset while in MEMRD.
   -> memRw=`IDEL, cacheEn=0, counters=0, all lines invalid; the next `RD 0x05 misses.
